wb_button_debounce: RTL and testbench

//  Upstream conditioning stage for the three user buttons. It synchronises and debounces the raw pad inputs.
//  Its debounced levels drive the 'buttons' input of the wishbone buttons/LEDs/ALU peripheral.
//  It also counts press events, holds sticky pending flags and raises an interrupt.
//  It is a wishbone slave on the same user-area bus.

---
 rtl/wb_button_debounce.sv | 133 +++++++++++++
 tb/tb_wb_button_debounce.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_button_debounce.sv
// Button conditioning for the user-area wishbone bus: synchronise, debounce,
// count presses, keep sticky pending flags and raise a level interrupt.
module wb_button_debounce #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0100,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  input  logic [2:0]  buttons_raw,
  output logic [2:0]  buttons_db,
  output logic        o_irq
);

  localparam logic [15:0] LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [2:0]  sync1;
  logic [2:0]  s;
  logic [2:0]  db;
  logic [15:0] dcnt [3];
  logic [2:0]  pending;
  logic [7:0]  cnt [3];
  logic [2:0]  irq_en;

  logic        req;
  logic        mapped;
  logic [31:0] offset;
  logic [1:0]  word;
  logic        wr;
  logic [2:0]  clr_pend;
  logic        clr_cnt;
  logic [2:0]  press;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign o_wb_stall  = 1'b0;
  assign buttons_db  = db;
  assign o_irq       = |(pending & irq_en);
  assign unused_bits = ^{i_wb_data[31:9], i_wb_data[7:3]};

  // A press is the edge on which a debounced bit is about to rise.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      press[i] = s[i] && !db[i] && (dcnt[i] == LAST);
    end
  end

  always_comb begin
    req      = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    offset   = i_wb_addr - BASE_ADDRESS;
    mapped   = (offset[31:4] == 28'd0) && (offset[1:0] == 2'd0);
    word     = offset[3:2];
    wr       = req && mapped && i_wb_we;
    clr_pend = (wr && word == 2'd2) ? i_wb_data[2:0] : 3'b000;
    clr_cnt  = wr && (word == 2'd2) && i_wb_data[8];
    case (word)
      2'd0:    rd_data = {25'd0, pending, 1'b0, db};
      2'd1:    rd_data = {8'd0, cnt[2], cnt[1], cnt[0]};
      2'd3:    rd_data = {29'd0, irq_en};
      default: rd_data = 32'd0;
    endcase
    if (!mapped) begin
      rd_data = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b000;
      s     <= 3'b000;
      db    <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        dcnt[i] <= 16'd0;
      end
    end else begin
      sync1 <= buttons_raw;
      s     <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (s[i] == db[i]) begin
          dcnt[i] <= 16'd0;
        end else if (dcnt[i] == LAST) begin
          db[i]   <= s[i];
          dcnt[i] <= 16'd0;
        end else begin
          dcnt[i] <= dcnt[i] + 16'd1;
        end
      end
    end
  end

  // Set beats clear: a press on the clearing edge still leaves its flag and a count of 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= 8'd0;
      end
    end else begin
      pending <= (pending & ~clr_pend) | press;
      for (int i = 0; i < 3; i++) begin
        if (clr_cnt) begin
          cnt[i] <= {7'd0, press[i]};
        end else if (press[i]) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= 32'd0;
      irq_en    <= 3'b000;
    end else begin
      o_wb_ack <= req && mapped;
      if (req && !i_wb_we) begin
        o_wb_data <= rd_data;
      end
      if (wr && word == 2'd3) begin
        irq_en <= i_wb_data[2:0];
      end
    end
  end

endmodule

// File: tb/tb_wb_button_debounce.sv
// Directed bench for wb_button_debounce: bus reads push expected data into a
// scoreboard queue that a negedge monitor pops whenever the DUT acks.
module tb_wb_button_debounce;

  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic        ack, stall, irq;
  logic [31:0] rdata;
  logic [2:0]  raw, db;

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_button_debounce #(.BASE_ADDRESS(BASE), .DEBOUNCE_CYCLES(16'd4)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdata),
    .buttons_raw(raw), .buttons_db(db), .o_irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry; reads compare the data.
  always @(negedge clk) begin
    exp_t e;
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=ack required=no_ack");
      end else begin
        e = sbq.pop_front();
        if (e.is_read) check("read_data", rdata, e.data);
      end
    end
  end

  task automatic wb_xfer(input string name, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_ack);
    exp_t e;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    e.is_read = !w;
    e.data    = exp_rd;
    if (exp_ack) sbq.push_back(e);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check({name, "_ack"}, {31'd0, ack}, {31'd0, exp_ack});
    @(negedge clk);
    check({name, "_ack_drop"}, {31'd0, ack}, 32'd0);
  endtask

  task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    wb_xfer(name, 1'b0, BASE + off, 32'd0, exp, 1'b1);
  endtask

  task automatic wr(input string name, input logic [31:0] off, input logic [31:0] d);
    wb_xfer(name, 1'b1, BASE + off, d, 32'd0, 1'b1);
  endtask

  task automatic set_raw(input logic [2:0] v);
    @(posedge clk); #1;
    raw = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    reset = 1'b1; raw = 3'b000;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1. reset state
    @(negedge clk);
    check("reset_db", {29'd0, db}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    rd("rst_status", 32'd0, 32'h0);
    rd("rst_count", 32'd4, 32'h0);
    rd("rst_irq_en", 32'd12, 32'h0);

    // 2. exact debounce latency on button 0
    set_raw(3'b001);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("lat_early", {31'd0, db[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_exact", {31'd0, db[0]}, 32'd1);
    rd("t2_status", 32'd0, 32'h11);
    rd("t2_count", 32'd4, 32'h01);
    wr("clear_all", 32'd8, 32'h107);

    // 3. bounce on button 1: a 3-sample burst is rejected
    for (int i = 0; i < 3; i++) set_raw(3'b011);
    set_raw(3'b001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("burst_db1", {31'd0, db[1]}, 32'd0);
    end
    pat = 8'b1111_0111;
    for (int i = 0; i < 8; i++) set_raw({1'b0, pat[i], 1'b1});
    repeat (8) @(posedge clk);
    rd("t3_count", 32'd4, 32'h100);
    rd("t3_status", 32'd0, 32'h23);

    // 4. interrupt path
    wr("irq_en_wr", 32'd12, 32'hFFFF_FFFC);
    rd("irq_en_rd", 32'd12, 32'h4);
    check("irq_masked", {31'd0, irq}, 32'd0);
    set_raw(3'b111);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    rd("t4_status", 32'd0, 32'h67);
    wr("clear_p2", 32'd8, 32'h4);
    check("irq_clr", {31'd0, irq}, 32'd0);
    rd("t4_status2", 32'd0, 32'h27);

    // 5. release makes no event; press collides with CLEAR on the same edge
    set_raw(3'b110);
    repeat (8) @(posedge clk);
    rd("release_status", 32'd0, 32'h26);
    set_raw(3'b111);
    repeat (4) @(posedge clk);
    wr("clear_collide", 32'd8, 32'h1);
    rd("collide_status", 32'd0, 32'h37);
    rd("collide_count", 32'd4, 32'h010101);

    wr("clear_cnt", 32'd8, 32'h100);
    for (int n = 0; n < 255; n++) begin
      set_raw(3'b110);
      repeat (7) @(posedge clk);
      set_raw(3'b111);
      repeat (7) @(posedge clk);
    end
    rd("count_255", 32'd4, 32'h0000FF);
    set_raw(3'b110);
    repeat (7) @(posedge clk);
    set_raw(3'b111);
    repeat (7) @(posedge clk);
    rd("count_wrap", 32'd4, 32'h000000);

    set_raw(3'b110);
    repeat (8) @(posedge clk);
    set_raw(3'b111);
    repeat (4) @(posedge clk);
    wr("cnt_clr_collide", 32'd8, 32'h100);
    rd("cnt_collide", 32'd4, 32'h000001);

    // 6. bus corner cases
    wb_xfer("unmapped16", 1'b0, BASE + 32'd16, 32'd0, 32'd0, 1'b0);
    wb_xfer("unmapped2", 1'b0, BASE + 32'd2, 32'd0, 32'd0, 1'b0);
    wb_xfer("unmapped_wr", 1'b1, BASE + 32'd16, 32'h7, 32'd0, 1'b0);
    wr("ro_write", 32'd0, 32'hFFFF_FFFF);
    rd("ro_status", 32'd0, 32'h37);
    rd("irq_en_kept", 32'd12, 32'h4);

    // reset during an in-flight ack while button 1 is mid-debounce
    set_raw(3'b101);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = BASE;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    check("pre_rst_ack", {31'd0, ack}, 32'd1);
    check("pre_rst_db", {29'd0, db}, 32'h7);
    #1 reset = 1'b1; raw = 3'b000;
    #1;
    check("rst_ack_async", {31'd0, ack}, 32'd0);
    check("rst_db_async", {29'd0, db}, 32'd0);
    check("rst_irq_async", {31'd0, irq}, 32'd0);
    check("rst_rdata_async", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rst_db", {29'd0, db}, 32'd0);
    rd("post_rst_status", 32'd0, 32'h0);
    rd("post_rst_count", 32'd4, 32'h0);

    check("scoreboard_drain", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
